// File: rtl/frame_compositor.sv
// frame_compositor: VGA timing generator and tile/sprite/heart
// compositor with a two-stage pixel pipeline to the DAC pins.

package frame_compositor_pkg;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    logic frame_start;
  } sync_t;

  typedef struct packed {
    sync_t      sync;
    logic [7:0] tile;
    logic       heart;
    logic       mario;
    logic       goomba;
    logic       goomba_2;
  } s0_s1_t;

endpackage

module frame_compositor #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int BLOCK_WIDTH     = 40,
  parameter int CHARACTER_WIDTH = 42,
  parameter int HEART_SIZE      = 16,
  parameter int HEART_PITCH     = 24
) (
  input  logic               vga_clock,
  input  logic               reset,
  input  logic [7:0]         background [11:0][16:0],
  input  logic signed [31:0] mario_x,
  input  logic signed [31:0] mario_y,
  input  logic signed [31:0] goomba_x,
  input  logic signed [31:0] goomba_y,
  input  logic signed [31:0] goomba_2x,
  input  logic signed [31:0] goomba_2y,
  input  logic               show_hearts,
  input  logic signed [31:0] lives,
  output logic               hsync,
  output logic               vsync,
  output logic               blank_n,
  output logic [11:0]        rgb,
  output logic               frame_start
);

  import frame_compositor_pkg::*;

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int TW = $clog2(BLOCK_WIDTH);
  localparam int HEART_MARGIN = 8;
  localparam int HEART_COUNT  = 3;
  localparam int OFF_SCREEN   = 1000;

  localparam logic [11:0] C_HEART  = 12'hF00;
  localparam logic [11:0] C_MARIO  = 12'hE22;
  localparam logic [11:0] C_GOOMBA = 12'h840;

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic [TW-1:0] tile_x;
  logic [TW-1:0] tile_y;
  logic [4:0]    tile_col;
  logic [4:0]    tile_row;
  logic          h_last;
  logic          v_last;

  logic signed [31:0] px;
  logic signed [31:0] py;

  logic signed [31:0] snap_mario_x;
  logic signed [31:0] snap_mario_y;
  logic signed [31:0] snap_goomba_x;
  logic signed [31:0] snap_goomba_y;
  logic signed [31:0] snap_goomba_2x;
  logic signed [31:0] snap_goomba_2y;
  logic               snap_show;
  logic signed [31:0] snap_lives;
  logic               snap_en;

  logic [4:0]         col_idx;
  logic [3:0]         row_idx;
  logic signed [31:0] n_hearts;
  logic               heart_x;

  s0_s1_t      s0;
  s0_s1_t      s1;
  logic [11:0] colour;

  assign h_last = h_count == HW'(H_TOTAL - 1);
  assign v_last = v_count == VW'(V_TOTAL - 1);
  assign px     = 32'(h_count);
  assign py     = 32'(v_count);

  // Only 16 columns and 12 rows exist on screen; off-screen
  // positions fold to tile 0 and are blanked downstream.
  assign col_idx = (tile_col < 5'd16) ? tile_col : 5'd0;
  assign row_idx = (tile_row < 5'd12) ? tile_row[3:0]
                                      : 4'd0;

  function automatic logic box_hit(
    input logic signed [31:0] x,
    input logic signed [31:0] y,
    input logic signed [31:0] sx,
    input logic signed [31:0] sy
  );
    return x >= sx && x <= sx + CHARACTER_WIDTH - 1 &&
           y >= sy && y <= sy + CHARACTER_WIDTH - 1;
  endfunction

  // Raster counters plus tile column/row tracking (no divider).
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      h_count  <= '0;
      v_count  <= '0;
      tile_x   <= '0;
      tile_y   <= '0;
      tile_col <= '0;
      tile_row <= '0;
    end else if (h_last) begin
      h_count  <= '0;
      tile_x   <= '0;
      tile_col <= '0;
      if (v_last) begin
        v_count  <= '0;
        tile_y   <= '0;
        tile_row <= '0;
      end else begin
        v_count <= v_count + VW'(1);
        if (tile_y == TW'(BLOCK_WIDTH - 1)) begin
          tile_y   <= '0;
          tile_row <= tile_row + 5'd1;
        end else begin
          tile_y <= tile_y + TW'(1);
        end
      end
    end else begin
      h_count <= h_count + HW'(1);
      if (tile_x == TW'(BLOCK_WIDTH - 1)) begin
        tile_x   <= '0;
        tile_col <= tile_col + 5'd1;
      end else begin
        tile_x <= tile_x + TW'(1);
      end
    end
  end

  assign snap_en = (px == 0) && (py == V_VISIBLE);

  // Freeze sprite/HUD state once per frame, in vertical blank.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      snap_mario_x   <= OFF_SCREEN;
      snap_mario_y   <= OFF_SCREEN;
      snap_goomba_x  <= OFF_SCREEN;
      snap_goomba_y  <= OFF_SCREEN;
      snap_goomba_2x <= OFF_SCREEN;
      snap_goomba_2y <= OFF_SCREEN;
      snap_show      <= 1'b0;
      snap_lives     <= '0;
    end else if (snap_en) begin
      snap_mario_x   <= mario_x;
      snap_mario_y   <= mario_y;
      snap_goomba_x  <= goomba_x;
      snap_goomba_y  <= goomba_y;
      snap_goomba_2x <= goomba_2x;
      snap_goomba_2y <= goomba_2y;
      snap_show      <= show_hearts;
      snap_lives     <= lives;
    end
  end

  // Stage 0: sync decode, tile fetch and hit tests.
  always_comb begin
    s0       = '0;
    heart_x  = 1'b0;
    n_hearts = snap_lives;
    if (snap_lives < 0) n_hearts = 0;
    if (snap_lives > HEART_COUNT) n_hearts = HEART_COUNT;

    s0.sync.hsync = !(px >= H_VISIBLE + H_FRONT &&
                      px <  H_VISIBLE + H_FRONT + H_SYNC);
    s0.sync.vsync = !(py >= V_VISIBLE + V_FRONT &&
                      py <  V_VISIBLE + V_FRONT + V_SYNC);
    s0.sync.blank_n     = px < H_VISIBLE && py < V_VISIBLE;
    s0.sync.frame_start = (px == 0) && (py == 0);

    s0.tile = background[row_idx][col_idx];

    s0.mario = box_hit(px, py, snap_mario_x,
                       snap_mario_y);
    s0.goomba = box_hit(px, py, snap_goomba_x,
                        snap_goomba_y);
    s0.goomba_2 = box_hit(px, py, snap_goomba_2x,
                          snap_goomba_2y);

    for (int i = 0; i < HEART_COUNT; i++) begin
      if (i < n_hearts &&
          px >= HEART_MARGIN + HEART_PITCH * i &&
          px <= HEART_MARGIN + HEART_PITCH * i +
                HEART_SIZE - 1)
        heart_x = 1'b1;
    end
    s0.heart = heart_x && snap_show &&
               py >= HEART_MARGIN &&
               py <= HEART_MARGIN + HEART_SIZE - 1;
  end

  // Stage 1 register.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      s1            <= '0;
      s1.sync.hsync <= 1'b1;
      s1.sync.vsync <= 1'b1;
    end else begin
      s1 <= s0;
    end
  end

  // Layer priority: heart, Mario, goombas, then tile.
  always_comb begin
    colour = 12'h000;
    unique case (s1.tile)
      8'd0:    colour = 12'h000;
      8'd1:    colour = 12'h6AF;
      8'd2:    colour = 12'hC60;
      8'd3:    colour = 12'h830;
      8'd4:    colour = 12'hFD0;
      8'd5:    colour = 12'hFFF;
      8'd6:    colour = 12'h222;
      default: colour = 12'h000;
    endcase
    if (s1.heart)
      colour = C_HEART;
    else if (s1.mario)
      colour = C_MARIO;
    else if (s1.goomba || s1.goomba_2)
      colour = C_GOOMBA;
  end

  // Stage 2: output pins, colour forced black in blanking.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      rgb         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= s1.sync.blank_n ? colour : 12'h000;
      hsync       <= s1.sync.hsync;
      vsync       <= s1.sync.vsync;
      blank_n     <= s1.sync.blank_n;
      frame_start <= s1.sync.frame_start;
    end
  end

endmodule

// File: doc/frame_compositor.md
Name: frame_compositor

Overview:
- Display-side consumer of the game-logic outputs: the selected level's tile map, Mario/goomba positions, the hearts flag and the lives count.
- Generates 640x480@60 VGA timing and composites a 12-bit RGB pixel stream from tiles, sprites and a hearts overlay.
- Sits between the game-state controller and the board VGA DAC.
- Sprite and HUD inputs are snapshotted once per frame so mid-frame game updates cannot tear the image.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- BLOCK_WIDTH, 40, tile edge in pixels
- CHARACTER_WIDTH, 42, sprite edge in pixels (square)
- HEART_SIZE, 16, heart square edge
- HEART_PITCH, 24, horizontal spacing of hearts

Ports:
- vga_clock  in  1  pixel clock (25.175 MHz nominal)
- reset  in  1  asynchronous active-low reset
- background  in  byte [11:0][16:0]  tile codes [row][col]; 0=BDR 1=SKY 2=BLK 3=GND 4=TKN 5=CK1 6=CK2
- mario_x, mario_y  in  int  Mario top-left (signed)
- goomba_x, goomba_y  in  int  goomba 1 top-left
- goomba_2x, goomba_2y  in  int  goomba 2 top-left
- show_hearts  in  1  enable hearts overlay
- lives  in  int  lives count
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- blank_n  out  1  high during visible pixels
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}; 0 whenever blank_n=0
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) at the output

Behaviour:
- Counters:
  - h_count runs 0..799 and wraps to 0.
  - v_count increments when h_count wraps; it runs 0..524 and wraps to 0.
  - Both counters are 0 out of reset.
- Sync, stage 0 values:
  - hsync=0 iff 656<=h_count<=751.
  - vsync=0 iff 490<=v_count<=491.
  - blank_n=1 iff h_count<640 and v_count<480.
- Pipeline:
  - Stage 1 registers the tile code at background[v_count/40][h_count/40] (column 16 is never addressed), the three sprite-hit flags and the heart-hit flag.
  - Stage 2 registers rgb.
  - hsync, vsync, blank_n and frame_start are delayed 2 cycles to match.
  - Total latency from counter value to pins is 2 cycles. Division by 40 is done by tracking tile column and row counters, not with a divider.
- Snapshot:
  - On the cycle h_count==0 && v_count==480, latch all six sprite coordinates, show_hearts and lives.
  - All stage-1 sprite and heart compares use the latched copies.
  - background is read live.
- Sprite hit: px in [sx, sx+CHARACTER_WIDTH-1] and py in [sy, sy+CHARACTER_WIDTH-1].
  - Compares are 32-bit signed.
  - Negative or off-screen coordinates (e.g. 1000) simply never hit; no clamping error.
- Hearts:
  - n = clamp(lives, 0, 3). Negative lives gives 0 hearts.
  - Heart i (i<n) covers x in [8+24i, 23+24i], y in [8, 23].
  - Hearts are shown only when the latched show_hearts=1.
- Priority: heart > Mario > goomba 1 > goomba 2 > tile.
- Colours:
  - Sprites and HUD: heart F00, Mario E22, goombas 840.
  - Tiles: BDR 000, SKY 6AF, BLK C60, GND 830, TKN FD0, CK1 FFF, CK2 222.
  - Any other tile code is 000.
- Reset:
  - Reset values: rgb=0, hsync=1, vsync=1, blank_n=0, frame_start=0.
  - Pipeline registers clear.
  - Snapshot registers reset to: positions 1000, show_hearts 0, lives 0.
  - Reset asserted mid-frame takes effect immediately (asynchronous).
  - On release, counting restarts at (0,0), and the first frame_start appears 2 cycles after the first clock edge with counters at (0,0).

Test Plan:
- Reset release, run 420000 cycles -> hsync period 800 cycles with low width 96; vsync period 420000 with low width 1600; frame_start exactly once per 420000 cycles; counters (0,0) map to output 2 cycles later.
- All tiles = 1 (SKY), sprites at 1000, show_hearts=0 -> every visible pixel rgb=6AF; rgb=000 in every blanked cycle.
- background[2][3]=2, rest SKY -> rgb=C60 exactly for x 120..159, y 80..119.
- Mario at (100,200), goomba at (120,210), both latched -> pixel (120,210)=E22; pixel (142,210)=840; pixel (162,210)=tile colour.
- mario_x changed from 100 to 300 at v_count=240 -> rest of that frame still uses 100; next frame shows 300.
- show_hearts=1 with lives=2 -> F00 at (8,8) and (32,23), no heart at (56,8); with lives=7 -> 3 hearts; with lives=-1 -> none.
